// File: rtl/schmidl_cox_preamble_inserter.sv
// Prefixes each outgoing frame with a Schmidl-Cox training symbol (CP + two identical
// halves read from a loadable RAM), then forwards a fixed number of payload samples.
module schmidl_cox_preamble_inserter #(
   parameter int FFT_SIZE = 1024,
   parameter int CP_SIZE  = 128,
   parameter int SAMPLE_W = 32,
   parameter int LEN_W    = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clear,
   input  logic [LEN_W-1:0]                payload_length,
   input  logic                            pre_wr_en,
   input  logic [$clog2(FFT_SIZE/2)-1:0]   pre_wr_addr,
   input  logic [SAMPLE_W-1:0]             pre_wr_data,
   output logic                            pre_wr_ready,
   input  logic [SAMPLE_W-1:0]             i_tdata,
   input  logic                            i_tlast,
   input  logic                            i_tvalid,
   output logic                            i_tready,
   output logic [SAMPLE_W-1:0]             o_tdata,
   output logic                            o_tlast,
   output logic                            o_tvalid,
   input  logic                            o_tready,
   output logic [15:0]                     frame_count
);

   localparam int H     = FFT_SIZE / 2;
   localparam int AW    = $clog2(H);
   localparam int CNT_W = (LEN_W > AW + 1) ? LEN_W : AW + 1;

   localparam logic [AW-1:0]    A_CP   = AW'(H - CP_SIZE);
   localparam logic [AW-1:0]    A_LAST = AW'(H - 1);
   localparam logic [CNT_W-1:0] N_CP   = CNT_W'(CP_SIZE - 1);
   localparam logic [CNT_W-1:0] N_H    = CNT_W'(H - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PRE_CP  = 3'd1;
   localparam logic [2:0] S_PRE_H1  = 3'd2;
   localparam logic [2:0] S_PRE_H2  = 3'd3;
   localparam logic [2:0] S_PAYLOAD = 3'd4;

   logic [2:0]          r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_len;
   logic [AW-1:0]       r_addr;
   logic [SAMPLE_W-1:0] r_ram [H];
   logic [SAMPLE_W-1:0] r_ram_q_p1;
   logic [SAMPLE_W-1:0] r_pay_p1;
   logic                r_sel_pay_p1;
   logic                r_vld_p1;
   logic                r_last_p1;

   logic w_adv;
   logic w_start;
   logic w_pre;
   logic w_pay_rdy;
   logic w_pay_acc;
   logic w_seg_end;
   logic w_pay_end;
   logic w_unused;

   // The whole pipeline moves as one: a stalled output freezes address, RAM read and FSM.
   assign w_adv     = !o_tvalid || o_tready;
   // Waiting for stage 1 to empty guarantees two idle output cycles between frames.
   assign w_start   = (r_state == S_IDLE) && i_tvalid && !r_vld_p1;
   assign w_pre     = (r_state == S_PRE_CP) || (r_state == S_PRE_H1) || (r_state == S_PRE_H2);
   assign w_pay_rdy = (r_state == S_PAYLOAD) && w_adv && (r_cnt < r_len);
   assign w_pay_acc = w_pay_rdy && i_tvalid;
   assign w_seg_end = (r_state == S_PRE_CP) ? (r_cnt == N_CP) : (r_cnt == N_H);
   assign w_pay_end = ((r_cnt + CNT_W'(1)) == r_len);

   assign i_tready     = w_pay_rdy;
   assign pre_wr_ready = (r_state == S_IDLE);
   assign w_unused     = i_tlast;

   // Stage 0: sequencing and address generation; stage 1/2 control and output flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_len        <= '0;
         r_addr       <= '0;
         r_vld_p1     <= 1'b0;
         r_last_p1    <= 1'b0;
         r_sel_pay_p1 <= 1'b0;
         o_tvalid     <= 1'b0;
         o_tlast      <= 1'b0;
         o_tdata      <= '0;
         frame_count  <= '0;
      end else if (clear) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_addr       <= '0;
         r_vld_p1     <= 1'b0;
         r_last_p1    <= 1'b0;
         r_sel_pay_p1 <= 1'b0;
         o_tvalid     <= 1'b0;
         o_tlast      <= 1'b0;
         frame_count  <= '0;
      end else begin
         if (o_tvalid && o_tready && o_tlast) begin
            frame_count <= frame_count + 16'd1;
         end
         if (w_adv) begin
            r_vld_p1     <= w_pre || w_pay_acc;
            r_sel_pay_p1 <= w_pay_acc;
            r_last_p1    <= 1'b0;
            o_tvalid     <= r_vld_p1;
            o_tlast      <= r_vld_p1 && r_last_p1;
            if (r_vld_p1) begin
               o_tdata <= r_sel_pay_p1 ? r_pay_p1 : r_ram_q_p1;
            end
            case (r_state)
               S_IDLE: begin
                  if (w_start) begin
                     r_state <= S_PRE_CP;
                     r_cnt   <= '0;
                     r_addr  <= A_CP;
                     r_len   <= CNT_W'(payload_length);
                  end
               end
               S_PRE_CP, S_PRE_H1, S_PRE_H2: begin
                  r_addr <= (r_addr == A_LAST) ? '0 : r_addr + AW'(1);
                  if (w_seg_end) begin
                     r_cnt <= '0;
                     if (r_state == S_PRE_CP) begin
                        r_state <= S_PRE_H1;
                     end else if (r_state == S_PRE_H1) begin
                        r_state <= S_PRE_H2;
                     end else if (r_len == '0) begin
                        r_state   <= S_IDLE;
                        r_last_p1 <= 1'b1;
                     end else begin
                        r_state <= S_PAYLOAD;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_PAYLOAD: begin
                  if (w_pay_acc) begin
                     if (w_pay_end) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_last_p1 <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Stage 1 data: RAM is unreset storage; reads and payload capture follow the pipeline enable
   always_ff @(posedge clk) begin
      if (pre_wr_en && pre_wr_ready) begin
         r_ram[pre_wr_addr] <= pre_wr_data;
      end
      if (w_adv) begin
         r_ram_q_p1 <= r_ram[r_addr];
      end
      if (w_pay_acc) begin
         r_pay_p1 <= i_tdata;
      end
   end

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// Scoreboard bench for schmidl_cox_preamble_inserter (FFT_SIZE=16, CP_SIZE=4, RAM[k]=k).
module tb_schmidl_cox_preamble_inserter;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [15:0] payload_length;
   logic        pre_wr_en;
   logic [2:0]  pre_wr_addr;
   logic [31:0] pre_wr_data;
   logic        pre_wr_ready;
   logic [31:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        i_tready;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        o_tvalid;
   logic        o_tready;
   logic [15:0] frame_count;

   schmidl_cox_preamble_inserter #(
      .FFT_SIZE(16), .CP_SIZE(4), .SAMPLE_W(32), .LEN_W(16)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .payload_length(payload_length),
      .pre_wr_en(pre_wr_en), .pre_wr_addr(pre_wr_addr), .pre_wr_data(pre_wr_data),
      .pre_wr_ready(pre_wr_ready),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Hand-computed preamble for RAM[k]=k, H=8, CP=4
   localparam int PRE [20] = '{4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};

   int          checks = 0;
   int          failures = 0;
   int          out_seen = 0;
   int          in_cnt = 0;
   int          run = 0;
   int          max_run = 0;
   logic        rnd = 1'b0;
   logic [32:0] exp_q [$];
   logic [31:0] in_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int base, input int len);
      for (int i = 0; i < 20; i++) exp_q.push_back({(len == 0 && i == 19), 32'(PRE[i])});
      for (int i = 0; i < len; i++) begin
         exp_q.push_back({(i == len - 1), 32'(base + i)});
         in_q.push_back(32'(base + i));
      end
   endtask

   task automatic wait_seen(input int target, input string name);
      int n = 0;
      while (out_seen < target && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_reached"}, 32'(out_seen >= target), 32'd1);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #2;
   endtask

   // Input stream and output back-pressure driver
   initial begin : driver
      logic        in_hs;
      logic [31:0] tmp;
      forever begin
         @(negedge clk);
         in_hs = i_tvalid && i_tready;
         @(posedge clk);
         #1;
         if (in_hs && in_q.size() > 0) begin
            tmp = in_q.pop_front();
            in_cnt++;
         end
         if (in_q.size() == 0) begin
            i_tvalid = 1'b0;
         end else if (!(i_tvalid && !in_hs)) begin
            i_tvalid = (!rnd || $urandom_range(3) != 0);
            i_tdata  = in_q[0];
         end else begin
            i_tdata = in_q[0];
         end
         o_tready = rnd ? 1'($urandom_range(1)) : 1'b1;
      end
   end

   // Output monitor: pops the scoreboard on every handshake and checks hold stability
   logic        hold_pend = 1'b0;
   logic [31:0] hold_d;
   logic        hold_l;
   logic [32:0] e;
   always @(negedge clk) begin
      if (reset) begin
         hold_pend = 1'b0;
         run = 0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", 32'(o_tvalid), 32'd1);
            chk("hold_data", o_tdata, hold_d);
            chk("hold_last", 32'(o_tlast), 32'(hold_l));
         end
         if (o_tvalid) run++;
         else run = 0;
         if (run > max_run) max_run = run;
         if (o_tvalid && o_tready) begin
            out_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_output", o_tdata, 32'hDEAD_BEEF);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", o_tdata, e[31:0]);
               chk("out_last", 32'(o_tlast), 32'(e[32]));
            end
         end
         hold_pend = o_tvalid && !o_tready;
         hold_d    = o_tdata;
         hold_l    = o_tlast;
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base;
      int c0;
      reset = 1'b1; clear = 1'b0; payload_length = 16'd8;
      pre_wr_en = 1'b0; pre_wr_addr = '0; pre_wr_data = '0;
      i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_o_tvalid", 32'(o_tvalid), 32'd0);
      chk("rst_o_tlast", 32'(o_tlast), 32'd0);
      chk("rst_o_tdata", o_tdata, 32'd0);
      chk("rst_i_tready", 32'(i_tready), 32'd0);
      chk("rst_pre_wr_ready", 32'(pre_wr_ready), 32'd1);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #2;
      for (int k = 0; k < 8; k++) begin
         pre_wr_en = 1'b1; pre_wr_addr = 3'(k); pre_wr_data = 32'(k);
         @(posedge clk);
         #2;
      end
      pre_wr_en = 1'b0;

      // Basic frame, length 8
      max_run = 0;
      push_frame(100, 8);
      wait_drain("s1");
      chk("s1_valid_run", 32'(max_run), 32'd28);
      chk("s1_frame_count", 32'(frame_count), 32'd1);

      // Zero-length frame: preamble only, trigger sample never consumed
      payload_length = 16'd0;
      c0 = in_cnt;
      base = out_seen;
      push_frame(0, 0);
      in_q.push_back(32'd999);
      wait_seen(base + 1, "s2_start");
      in_q.delete();
      wait_drain("s2");
      chk("s2_inputs_consumed", 32'(in_cnt - c0), 32'd0);
      chk("s2_frame_count", 32'(frame_count), 32'd2);
      payload_length = 16'd8;

      // Three back-to-back frames under random back-pressure and input gaps
      rnd = 1'b1;
      for (int f = 0; f < 3; f++) push_frame(100, 8);
      wait_drain("s3");
      rnd = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("s3_frame_count", 32'(frame_count), 32'd5);

      // RAM write while the preamble is streaming must be dropped
      base = out_seen;
      push_frame(100, 8);
      wait_seen(base + 6, "s4_mid_h1");
      #2;
      chk("s4_pre_wr_ready", 32'(pre_wr_ready), 32'd0);
      pre_wr_en = 1'b1; pre_wr_addr = 3'd2; pre_wr_data = 32'hFFFF;
      @(posedge clk);
      #2;
      pre_wr_en = 1'b0;
      wait_drain("s4a");
      push_frame(100, 8);
      wait_drain("s4b");
      chk("s4_frame_count", 32'(frame_count), 32'd7);

      // Length change mid-payload applies only to the following frame
      base = out_seen;
      push_frame(300, 8);
      push_frame(400, 3);
      wait_seen(base + 22, "s5_payload");
      #2;
      payload_length = 16'd3;
      wait_drain("s5");
      chk("s5_frame_count", 32'(frame_count), 32'd9);
      payload_length = 16'd8;

      // Synchronous clear mid-frame
      base = out_seen;
      push_frame(100, 8);
      wait_seen(base + 5, "s6_mid");
      #2;
      clear = 1'b1;
      @(posedge clk);
      #2;
      clear = 1'b0;
      in_q.delete();
      exp_q.delete();
      i_tvalid = 1'b0;
      chk("s6_clear_o_tvalid", 32'(o_tvalid), 32'd0);
      chk("s6_clear_frame_count", 32'(frame_count), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      push_frame(100, 8);
      wait_drain("s6");
      chk("s6_frame_count", 32'(frame_count), 32'd1);

      // Asynchronous reset in the middle of the second half-symbol
      base = out_seen;
      push_frame(100, 8);
      wait_seen(base + 14, "s7_mid_h2");
      #3;
      reset = 1'b1;
      in_q.delete();
      exp_q.delete();
      i_tvalid = 1'b0;
      #1;
      chk("s7_rst_o_tvalid", 32'(o_tvalid), 32'd0);
      chk("s7_rst_o_tlast", 32'(o_tlast), 32'd0);
      chk("s7_rst_frame_count", 32'(frame_count), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #2;
      push_frame(100, 8);
      wait_drain("s7");
      chk("s7_frame_count", 32'(frame_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
